// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial three-channel adder: FSM state
//   encoding, channel indices, default sizing and the full-adder carry
//   function.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CH_ONE   = 2'd0,
        CH_TWO   = 2'd1,
        CH_THREE = 2'd2
    } ch_t;

    // Carry out of a 1-bit full adder.
    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// -----------------------------------------------------------------------------
// serial_fa_cell
//   One-bit full adder with a registered carry, shared by all three channels.
//
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset (clears carry)
//   en         : advance the carry register by one bit
//   clr        : synchronous carry clear (start of each channel)
//   a, b       : current operand bits
//   sum        : combinational sum bit a ^ b ^ carry
//   carry_next : combinational carry out of this bit position
// -----------------------------------------------------------------------------
module serial_fa_cell
    import serial_adder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry_next
);

    logic carry;

    assign sum        = a ^ b ^ carry;
    assign carry_next = majority(a, b, carry);

    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // blocking assignments here would make results depend on block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            carry <= 1'b0;
        end else if (en) begin
            carry <= carry_next;
        end
    end

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial three-channel adder. A single full-adder cell walks channel 1,
//   then 2, then 3, LSB first, one bit per clock. All three sums and carries
//   are published together in the DONE cycle.
//
//   clk                  : rising-edge clock
//   rst_n                : synchronous active-low reset
//   start                : request pulse, honoured only in IDLE
//   da_*/db_*            : per-channel operands, latched on the accepting edge
//   busy                 : high during the 3*WIDTH calculation cycles
//   done                 : one-cycle pulse when sum_*/cout_* update
//   sum_*                : (da_* + db_*) mod 2^WIDTH
//   cout_*               : carry out of each channel
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] da_one,
    input  logic [WIDTH-1:0] db_one,
    input  logic [WIDTH-1:0] da_two,
    input  logic [WIDTH-1:0] db_two,
    input  logic [WIDTH-1:0] da_three,
    input  logic [WIDTH-1:0] db_three,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_one,
    output logic [WIDTH-1:0] sum_two,
    output logic [WIDTH-1:0] sum_three,
    output logic             cout_one,
    output logic             cout_two,
    output logic             cout_three
);

    state_t           state;
    ch_t              ch;
    logic [CNT_W-1:0] bit_cnt;

    logic [WIDTH-1:0] a_sr [3];
    logic [WIDTH-1:0] b_sr [3];
    logic [WIDTH-1:0] r_sr [3];
    logic             cout_one_r;
    logic             cout_two_r;

    logic a_bit;
    logic b_bit;
    logic fa_sum;
    logic fa_carry_next;
    logic last_bit;
    logic accept;

    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
    assign accept   = (state == S_IDLE) && start;

    // Select the LSB of the channel currently being processed.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred when ch holds an unused encoding.
        a_bit = 1'b0;
        b_bit = 1'b0;
        case (ch)
            CH_ONE: begin
                a_bit = a_sr[0][0];
                b_bit = b_sr[0][0];
            end
            CH_TWO: begin
                a_bit = a_sr[1][0];
                b_bit = b_sr[1][0];
            end
            CH_THREE: begin
                a_bit = a_sr[2][0];
                b_bit = b_sr[2][0];
            end
            default: ;
        endcase
    end

    // Carry is cleared on accept and after each channel's final bit so the
    // next channel starts from a zero carry-in.
    serial_fa_cell u_fa (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state == S_CALC),
        .clr        (accept || ((state == S_CALC) && last_bit)),
        .a          (a_bit),
        .b          (b_bit),
        .sum        (fa_sum),
        .carry_next (fa_carry_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ch         <= CH_ONE;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cout_one_r <= 1'b0;
            cout_two_r <= 1'b0;
            sum_one    <= '0;
            sum_two    <= '0;
            sum_three  <= '0;
            cout_one   <= 1'b0;
            cout_two   <= 1'b0;
            cout_three <= 1'b0;
            // NOTE: the shift-register arrays are reset as well, so an
            // aborted run cannot leak partial operands or sums into later
            // results.
            for (int i = 0; i < 3; i++) begin
                a_sr[i] <= '0;
                b_sr[i] <= '0;
                r_sr[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr[0] <= da_one;
                        b_sr[0] <= db_one;
                        a_sr[1] <= da_two;
                        b_sr[1] <= db_two;
                        a_sr[2] <= da_three;
                        b_sr[2] <= db_three;
                        ch      <= CH_ONE;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_CALC;
                    end
                end

                S_CALC: begin
                    a_sr[ch] <= a_sr[ch] >> 1;
                    b_sr[ch] <= b_sr[ch] >> 1;
                    r_sr[ch] <= {fa_sum, r_sr[ch][WIDTH-1:1]};
                    if (last_bit) begin
                        bit_cnt <= '0;
                        case (ch)
                            CH_ONE: begin
                                cout_one_r <= fa_carry_next;
                                ch         <= CH_TWO;
                            end
                            CH_TWO: begin
                                cout_two_r <= fa_carry_next;
                                ch         <= CH_THREE;
                            end
                            default: begin
                                // Channel three's last bit and carry are
                                // still in flight on this edge, so they are
                                // taken straight from the adder cell.
                                sum_one    <= r_sr[0];
                                sum_two    <= r_sr[1];
                                sum_three  <= {fa_sum, r_sr[2][WIDTH-1:1]};
                                cout_one   <= cout_one_r;
                                cout_two   <= cout_two_r;
                                cout_three <= fa_carry_next;
                                ch         <= CH_ONE;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                state      <= S_DONE;
                            end
                        endcase
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder. A timeline model (idle / running for
//   3*W edges / one done cycle, with plain-arithmetic sums captured at accept)
//   predicts every output each cycle; directed cases pin the model with
//   hand-computed literals.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W   = 8;
    localparam int RUN = 3 * W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] da_one, db_one, da_two, db_two, da_three, db_three;
    logic         busy, done;
    logic [W-1:0] sum_one, sum_two, sum_three;
    logic         cout_one, cout_two, cout_three;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .da_one     (da_one),
        .db_one     (db_one),
        .da_two     (da_two),
        .db_two     (db_two),
        .da_three   (da_three),
        .db_three   (db_three),
        .busy       (busy),
        .done       (done),
        .sum_one    (sum_one),
        .sum_two    (sum_two),
        .sum_three  (sum_three),
        .cout_one   (cout_one),
        .cout_two   (cout_two),
        .cout_three (cout_three)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
    mmode_t   m_mode = M_IDLE;
    int       m_left = 0;
    logic [W:0] m_pend [3];
    logic [W:0] m_out  [3];   // {carry, sum} per channel
    logic     m_busy = 1'b0;
    logic     m_done = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_busy = 1'b0;
            m_done = 1'b0;
            for (int i = 0; i < 3; i++) m_out[i] = '0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_done = 1'b0;
                    if (start) begin
                        m_pend[0] = {1'b0, da_one}   + {1'b0, db_one};
                        m_pend[1] = {1'b0, da_two}   + {1'b0, db_two};
                        m_pend[2] = {1'b0, da_three} + {1'b0, db_three};
                        m_left = RUN;
                        m_busy = 1'b1;
                        m_mode = M_RUN;
                    end
                end
                M_RUN: begin
                    m_left--;
                    if (m_left == 0) begin
                        for (int i = 0; i < 3; i++) m_out[i] = m_pend[i];
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_mode = M_DONE;
                    end
                end
                default: begin
                    m_done = 1'b0;
                    m_mode = M_IDLE;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    bit check_en   = 1'b0;
    int done_count = 0;

    always @(negedge clk) begin
        if (check_en) begin
            check("busy",       busy,       m_busy);
            check("done",       done,       m_done);
            check("sum_one",    sum_one,    m_out[0][W-1:0]);
            check("sum_two",    sum_two,    m_out[1][W-1:0]);
            check("sum_three",  sum_three,  m_out[2][W-1:0]);
            check("cout_one",   cout_one,   m_out[0][W]);
            check("cout_two",   cout_two,   m_out[1][W]);
            check("cout_three", cout_three, m_out[2][W]);
            if (done) done_count++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ops(input logic [W-1:0] a1, b1, a2, b2, a3, b3);
        da_one = a1; db_one = b1; da_two = a2; db_two = b2; da_three = a3; db_three = b3;
    endtask

    // Waits (bounded) for done; lat counts negedges since the accepting edge.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    task automatic run_case(input logic [W-1:0] a1, b1, a2, b2, a3, b3,
                            output int lat, output int busy_n);
        @(negedge clk);
        set_ops(a1, b1, a2, b2, a3, b3);
        start = 1'b1;
        wait_done(lat, busy_n);
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] s1, s2, s3,
                              input logic c1, c2, c3);
        check({tag, "_s1"}, sum_one, s1);
        check({tag, "_s2"}, sum_two, s2);
        check({tag, "_s3"}, sum_three, s3);
        check({tag, "_c1"}, cout_one, c1);
        check({tag, "_c2"}, cout_two, c2);
        check({tag, "_c3"}, cout_three, c3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy_n, d0;
        int dq [$];

        rst_n = 1'b0;
        start = 1'b0;
        set_ops('0, '0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_outs("rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 1: basic sums, latency and busy length
        run_case(8'h12, 8'h34, 8'h01, 8'h01, 8'h7F, 8'h01, lat, busy_n);
        check("t1_latency", lat, 25);
        check("t1_busy_cycles", busy_n, 24);
        check_outs("t1", 8'h46, 8'h02, 8'h80, 1'b0, 1'b0, 1'b0);

        // 2: carries out of every channel
        run_case(8'hFF, 8'h01, 8'h80, 8'h80, 8'hFF, 8'hFF, lat, busy_n);
        check_outs("t2", 8'h00, 8'h00, 8'hFE, 1'b1, 1'b1, 1'b1);

        // 3: start during CALC and DONE is ignored
        @(negedge clk);
        set_ops(8'h12, 8'h34, 8'h01, 8'h01, 8'h7F, 8'h01);
        start = 1'b1;
        d0 = done_count;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start = (n == 3 || n == 20 || n == 25);
            if (n == 25) check("t3_done_at_25", done, 1);
        end
        check("t3_done_count", done_count - d0, 1);
        check("t3_idle_after", busy, 0);
        check_outs("t3", 8'h46, 8'h02, 8'h80, 1'b0, 1'b0, 1'b0);

        // 4: reset mid-run aborts without done
        @(negedge clk);
        set_ops(8'hFF, 8'h01, 8'h80, 8'h80, 8'hFF, 8'hFF);
        start = 1'b1;
        d0 = done_count;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t4_busy", busy, 0);
        check_outs("t4", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("t4_no_done", done_count - d0, 0);

        // 5: operand ports change right after the latch edge
        @(negedge clk);
        set_ops(8'h0F, 8'hF0, 8'hC8, 8'h64, 8'h99, 8'h88);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_ops(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
        wait_done(lat, busy_n);
        check_outs("t5", 8'hFF, 8'h2C, 8'h21, 1'b0, 1'b1, 1'b1);

        // 6: start held high, back-to-back runs
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 90; n++) begin
            set_ops(W'($urandom), W'($urandom), W'($urandom),
                    W'($urandom), W'($urandom), W'($urandom));
            @(negedge clk);
            if (done) dq.push_back(n);
        end
        start = 1'b0;
        check("t6_runs", dq.size(), 3);
        for (int i = 1; i < dq.size(); i++) check("t6_spacing", dq[i] - dq[i-1], 26);
        repeat (40) @(negedge clk);

        // randomized runs with idle gaps
        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_case(W'($urandom), W'($urandom), W'($urandom),
                     W'($urandom), W'($urandom), W'($urandom), lat, busy_n);
            check("rand_latency", lat, 25);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
